// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encoding and lamp constants for the intersection sequencer
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    FLASH   = 2'd3
  } phase_e;

  // Bit positions inside one approach's [0:2] lamp triple.
  localparam int LED_RED = 0;
  localparam int LED_YEL = 1;
  localparam int LED_GRN = 2;

  localparam logic [0:2] LAMP_RED = 3'b100;
  localparam logic [0:2] LAMP_YEL = 3'b010;
  localparam logic [0:2] LAMP_GRN = 3'b001;

endpackage

// File: rtl/next_light_picker.sv
// rtl/next_light_picker.sv - chooses the approach that receives the next green
module next_light_picker
  import traffic_pkg::*;
#(
  parameter int NUM_LIGHTS = 4,
  localparam int IW = $clog2(NUM_LIGHTS)
) (
  input  logic [NUM_LIGHTS-1:0] force_reds,
  input  logic [NUM_LIGHTS-1:0] preferentials,
  input  logic [IW-1:0]         active_idx,
  output logic [IW-1:0]         pick,
  output logic                  any_eligible
);

  logic [NUM_LIGHTS-1:0] eligible;
  logic [NUM_LIGHTS-1:0] active_mask;
  logic [NUM_LIGHTS-1:0] pref_mask;
  logic                  others_eligible;

  assign eligible        = ~force_reds;
  assign active_mask     = NUM_LIGHTS'(1) << active_idx;
  assign others_eligible = |(eligible & ~active_mask);
  assign any_eligible    = |eligible;

  // The approach just served only competes for priority when nobody else can go.
  assign pref_mask = eligible & preferentials & (others_eligible ? ~active_mask : '1);

  // Lowest preferential index wins; otherwise scan forward from the current approach.
  always_comb begin
    logic found;
    int   j;
    pick  = active_idx;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      if (!found && pref_mask[i]) begin
        pick  = IW'(i);
        found = 1'b1;
      end
    end
    for (int k = 1; k <= NUM_LIGHTS; k++) begin
      j = int'(active_idx) + k;
      if (j >= NUM_LIGHTS) j = j - NUM_LIGHTS;
      if (!found && eligible[j]) begin
        pick  = IW'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intersection_sequencer.sv
// rtl/intersection_sequencer.sv - N-approach traffic-light sequencer with priority, force-red and flash modes
module intersection_sequencer
  import traffic_pkg::*;
#(
  parameter int NUM_LIGHTS   = 4,
  parameter int TIMER_W      = 8,
  parameter int GREEN_TICKS  = 3,
  parameter int YELLOW_TICKS = 1,
  parameter int ALLRED_TICKS = 1,
  parameter int FLASH_TICKS  = 2,
  localparam int IW = $clog2(NUM_LIGHTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic                        attention,
  input  logic [NUM_LIGHTS-1:0]       force_reds,
  input  logic [NUM_LIGHTS-1:0]       preferentials,
  output logic [NUM_LIGHTS-1:0][0:2]  ltfs,
  output logic [NUM_LIGHTS-1:0]       lgreen,
  output logic [IW-1:0]               active_idx,
  output phase_e                      phase
);

  phase_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               flash_q, flash_d;
  logic [TIMER_W-1:0] dur_m1;
  logic               phase_end;
  logic [IW-1:0]      pick;
  logic               any_eligible;

  next_light_picker #(
    .NUM_LIGHTS(NUM_LIGHTS)
  ) u_picker (
    .force_reds   (force_reds),
    .preferentials(preferentials),
    .active_idx   (idx_q),
    .pick         (pick),
    .any_eligible (any_eligible)
  );

  // Last timer value of the phase currently running.
  always_comb begin
    dur_m1 = TIMER_W'(ALLRED_TICKS - 1);
    case (state_q)
      GREEN:   dur_m1 = TIMER_W'(GREEN_TICKS - 1);
      YELLOW:  dur_m1 = TIMER_W'(YELLOW_TICKS - 1);
      FLASH:   dur_m1 = TIMER_W'(FLASH_TICKS - 1);
      default: dur_m1 = TIMER_W'(ALLRED_TICKS - 1);
    endcase
  end

  assign phase_end = tick && (timer_q == dur_m1);

  // Next-state logic; priority is attention, then force-red of the green approach, then expiry.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    flash_d = flash_q;
    if (attention) begin
      if (state_q != FLASH) begin
        state_d = FLASH;
        timer_d = '0;
        flash_d = 1'b1;
      end else if (phase_end) begin
        timer_d = '0;
        flash_d = ~flash_q;
      end else if (tick) begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end else if (state_q == FLASH) begin
      // Leaving attention restarts service from approach 0 (or a preferential).
      state_d = ALL_RED;
      timer_d = '0;
      idx_d   = IW'(NUM_LIGHTS - 1);
    end else if (state_q == GREEN && force_reds[idx_q]) begin
      state_d = YELLOW;
      timer_d = '0;
    end else if (phase_end) begin
      timer_d = '0;
      case (state_q)
        ALL_RED: begin
          if (any_eligible) begin
            state_d = GREEN;
            idx_d   = pick;
          end
        end
        GREEN:   state_d = YELLOW;
        YELLOW:  state_d = ALL_RED;
        default: state_d = ALL_RED;
      endcase
    end else if (tick) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // State registers with synchronous reset into a clean all-red phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALL_RED;
      timer_q <= '0;
      idx_q   <= IW'(NUM_LIGHTS - 1);
      flash_q <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      flash_q <= flash_d;
    end
  end

  // Lamp decode from the registered state.
  always_comb begin
    for (int i = 0; i < NUM_LIGHTS; i++) ltfs[i] = LAMP_RED;
    lgreen = '0;
    case (state_q)
      GREEN: begin
        ltfs[idx_q]   = LAMP_GRN;
        lgreen[idx_q] = 1'b1;
      end
      YELLOW: ltfs[idx_q] = LAMP_YEL;
      FLASH: begin
        for (int i = 0; i < NUM_LIGHTS; i++) begin
          ltfs[i]          = '0;
          ltfs[i][LED_YEL] = flash_q;
        end
      end
      default: ;
    endcase
  end

  assign active_idx = idx_q;
  assign phase      = state_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// tb/tb_intersection_sequencer.sv - scoreboard bench for intersection_sequencer
module tb_intersection_sequencer;
  import traffic_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            tick;
  logic            attention;
  logic [3:0]      force_reds;
  logic [3:0]      preferentials;
  logic [3:0][0:2] ltfs;
  logic [3:0]      lgreen;
  logic [1:0]      active_idx;
  phase_e          phase;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    phase_e      ph;
    logic [1:0]  idx;
    logic [3:0]  lg;
    logic [11:0] lamps;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  intersection_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .attention    (attention),
    .force_reds   (force_reds),
    .preferentials(preferentials),
    .ltfs         (ltfs),
    .lgreen       (lgreen),
    .active_idx   (active_idx),
    .phase        (phase)
  );

  function automatic exp_t mk(phase_e ph, int idx, logic fl);
    logic [3:0][0:2] l;
    exp_t e;
    l    = {4{3'b100}};
    e.lg = '0;
    case (ph)
      GREEN:  begin l[idx] = 3'b001; e.lg[idx] = 1'b1; end
      YELLOW: l[idx] = 3'b010;
      FLASH:  l = {4{1'b0, fl, 1'b0}};
      default: ;
    endcase
    e.ph    = ph;
    e.idx   = 2'(idx);
    e.lamps = l;
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o.ph    = phase;
    o.idx   = active_idx;
    o.lg    = lgreen;
    o.lamps = ltfs;
    return o;
  endfunction

  task automatic push_round(int ch);
    repeat (3) sb.push_back(mk(GREEN, ch, 1'b1));
    sb.push_back(mk(YELLOW, ch, 1'b1));
    sb.push_back(mk(ALL_RED, ch, 1'b1));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    tick = 1'b1; attention = 1'b0; force_reds = '0; preferentials = '0;
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t o, e;
    defaults();
    do_reset();
    sb.push_back(mk(ALL_RED, 3, 1'b1));
    e = sb.pop_front(); o = obs(); total++;
    if (o !== e) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", o, e);
    end
  endtask

  task automatic test_rotation();
    exp_t o, e;
    int c;
    defaults();
    do_reset();
    sb.push_back(mk(ALL_RED, 3, 1'b1));
    push_round(0); push_round(1); push_round(2); push_round(3); push_round(0);
    c = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL rotation cyc=%0d got=%h want=%h", c, o, e);
      end
      total++;
      if (!$onehot0(lgreen)) begin
        bad++;
        $display("FAIL rotation_onehot cyc=%0d got=%b want=onehot0", c, lgreen);
      end
      step();
      c++;
    end
  endtask

  task automatic test_preferential();
    exp_t o, e;
    int c;
    defaults();
    do_reset();
    sb.push_back(mk(ALL_RED, 3, 1'b1));
    push_round(0); push_round(3); push_round(0); push_round(1);
    c = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL preferential cyc=%0d got=%h want=%h", c, o, e);
      end
      if (c == 1) preferentials = 4'b1000;
      if (c == 6) preferentials = 4'b0000;
      step();
      c++;
    end
  endtask

  task automatic test_force_red_static();
    exp_t o, e;
    int c;
    defaults();
    force_reds = 4'b0010;
    do_reset();
    sb.push_back(mk(ALL_RED, 3, 1'b1));
    push_round(0); push_round(2); push_round(3); push_round(0);
    c = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL force_static cyc=%0d got=%h want=%h", c, o, e);
      end
      step();
      c++;
    end
  endtask

  task automatic test_force_red_active();
    exp_t o, e;
    int c;
    defaults();
    do_reset();
    sb.push_back(mk(ALL_RED, 3, 1'b1));
    sb.push_back(mk(GREEN, 0, 1'b1));
    sb.push_back(mk(GREEN, 0, 1'b1));
    sb.push_back(mk(YELLOW, 0, 1'b1));
    sb.push_back(mk(ALL_RED, 0, 1'b1));
    push_round(1);
    sb.push_back(mk(GREEN, 2, 1'b1));
    c = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL force_active cyc=%0d got=%h want=%h", c, o, e);
      end
      if (c == 2) force_reds = 4'b0001;
      if (c == 5) force_reds = 4'b0000;
      step();
      c++;
    end
  endtask

  task automatic test_all_forced();
    exp_t o, e;
    int c;
    defaults();
    force_reds = 4'b1111;
    do_reset();
    repeat (11) sb.push_back(mk(ALL_RED, 3, 1'b1));
    push_round(2);
    sb.push_back(mk(GREEN, 2, 1'b1));
    c = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL all_forced cyc=%0d got=%h want=%h", c, o, e);
      end
      if (c == 10) force_reds = 4'b1011;
      step();
      c++;
    end
  endtask

  task automatic test_attention();
    exp_t o, e;
    int c;
    defaults();
    do_reset();
    sb.push_back(mk(ALL_RED, 3, 1'b1));
    sb.push_back(mk(GREEN, 0, 1'b1));
    sb.push_back(mk(GREEN, 0, 1'b1));
    sb.push_back(mk(FLASH, 0, 1'b1));
    sb.push_back(mk(FLASH, 0, 1'b1));
    sb.push_back(mk(FLASH, 0, 1'b0));
    sb.push_back(mk(FLASH, 0, 1'b0));
    sb.push_back(mk(FLASH, 0, 1'b1));
    sb.push_back(mk(FLASH, 0, 1'b1));
    sb.push_back(mk(ALL_RED, 3, 1'b1));
    sb.push_back(mk(GREEN, 0, 1'b1));
    c = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL attention cyc=%0d got=%h want=%h", c, o, e);
      end
      if (c == 2) begin attention = 1'b1; force_reds = 4'b0001; preferentials = 4'b0100; end
      if (c == 8) begin attention = 1'b0; force_reds = 4'b0000; preferentials = 4'b0000; end
      step();
      c++;
    end
  endtask

  task automatic test_tick_reset();
    exp_t o, e;
    int c;
    defaults();
    do_reset();
    sb.push_back(mk(ALL_RED, 3, 1'b1));
    repeat (9) sb.push_back(mk(GREEN, 0, 1'b1));
    sb.push_back(mk(YELLOW, 0, 1'b1));
    sb.push_back(mk(ALL_RED, 0, 1'b1));
    sb.push_back(mk(GREEN, 1, 1'b1));
    sb.push_back(mk(ALL_RED, 3, 1'b1));
    sb.push_back(mk(GREEN, 0, 1'b1));
    c = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL tick_reset cyc=%0d got=%h want=%h", c, o, e);
      end
      if (c == 1)  tick = 1'b0;
      if (c == 7)  tick = 1'b1;
      if (c == 12) rst  = 1'b1;
      if (c == 13) rst  = 1'b0;
      step();
      c++;
    end
  endtask

  initial begin
    rst = 1'b1;
    defaults();
    test_reset();
    test_rotation();
    test_preferential();
    test_force_red_static();
    test_force_red_active();
    test_all_forced();
    test_attention();
    test_tick_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
